// File: rtl/alu_pkg.sv
// Shared ALU op codes, op classification helpers and arbiter state encoding.
// Used by the alu datapath and by alu_arbiter (ALU_ARB_RR_EN selects round-robin).
package alu_pkg;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b110000;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_OR   = 6'b000110;
    localparam logic [5:0] ALU_AND  = 6'b000111;
    localparam logic [5:0] ALU_SLL  = 6'b100000;
    localparam logic [5:0] ALU_SRL  = 6'b100101;
    localparam logic [5:0] ALU_SRA  = 6'b110101;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [5:0] op);
        case (op)
            ALU_SLL, ALU_SRL, ALU_SRA: is_shift = 1'b1;
            default:                   is_shift = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-cycle 32-bit ALU datapath (module alu).
// Unknown op codes produce a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rvout,
    output logic        alu_zero
);

    always_comb begin
        rvout = '0;
        case (op)
            ALU_ADD:  rvout = a + b;
            ALU_SUB:  rvout = a - b;
            ALU_SLT:  rvout = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: rvout = {31'b0, a < b};
            ALU_XOR:  rvout = a ^ b;
            ALU_OR:   rvout = a | b;
            ALU_AND:  rvout = a & b;
            ALU_SLL:  rvout = a << b[4:0];
            ALU_SRL:  rvout = a >> b[4:0];
            ALU_SRA:  rvout = $unsigned($signed(a) >>> b[4:0]);
            default:  rvout = '0;
        endcase
    end

    assign alu_zero = (rvout == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one alu; one op in flight.
// Define ALU_ARB_RR_EN for round-robin, otherwise port 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [5:0]   req_op0,
    input  logic [5:0]   req_op1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err
);

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_grant_q, last_grant_d;
    logic [5:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         err_q, err_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic         rsp_err_q, rsp_err_d;

    logic         grant;
    logic         accept;
    logic [5:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W-1:0] alu_out;
    logic         alu_zero;

    always_comb begin
`ifdef ALU_ARB_RR_EN
        if (&req_valid) grant = ~last_grant_q;
        else            grant = req_valid[1];
`else
        grant = ~req_valid[0] & req_valid[1];
`endif
    end

    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE && !reset)
            req_ready = grant ? 2'b10 : 2'b01;
    end

    assign accept = |(req_valid & req_ready);
    assign sel_op = grant ? req_op1 : req_op0;
    assign sel_a  = grant ? req_a1 : req_a0;
    assign sel_b  = grant ? req_b1 : req_b0;

    alu u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .rvout    (alu_out),
        .alu_zero (alu_zero)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    owner_d      = grant;
                    last_grant_d = grant;
                    op_d         = sel_op;
                    a_d          = sel_a;
                    // shifts only see the 5-bit shift amount
                    b_d          = is_shift(sel_op) ? {27'b0, sel_b[4:0]} : sel_b;
                    err_d        = ~op_legal(sel_op);
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_data_d  = err_q ? '0 : alu_out;
                rsp_zero_d  = err_q ? 1'b0 : alu_zero;
                rsp_err_d   = err_q;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d     = IDLE;
                    rsp_valid_d = 2'b00;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU/arbiter model.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;
    logic model_lg;

    always #5 clk = ~clk;

    alu_arbiter #(.W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    // Reference: returns {err, zero, data}
    function automatic logic [33:0] ref_op(input logic [5:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b % 32);
        case (op)
            6'b000000: r = a + b;
            6'b110000: r = a - b;
            6'b000010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'b000011: r = (a < b) ? 32'd1 : 32'd0;
            6'b000100: r = a ^ b;
            6'b000110: r = a | b;
            6'b000111: r = a & b;
            6'b100000: r = a << sh;
            6'b100101: r = a >> sh;
            6'b110101: r = $unsigned($signed(a) >>> sh);
            default:   return {1'b1, 1'b0, 32'd0};
        endcase
        return {1'b0, (r == 32'd0), r};
    endfunction

    function automatic logic tie_winner(input logic lg);
`ifdef ALU_ARB_RR_EN
        return ~lg;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_port(input int p, input logic [5:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    // Single-requester transaction; returns at the negedge rsp_valid is seen.
    task automatic issue(input int p, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic ok);
        ok = 1'b0;
        lat = 0;
        @(negedge clk);
        set_port(p, op, a, b);
        req_valid[p] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[p]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        model_lg = p[0];
        @(negedge clk);
        req_valid[p] = 1'b0;
        ok = 1'b0;
        for (int i = 1; i < 20; i++) begin
            lat = i;
            if (rsp_valid[p]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=00", req_ready);
        end
        req_valid = 2'b00;
        reset = 1'b0;
        model_lg = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_err} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h/%b/%b exp=0",
                     rsp_valid, rsp_data, rsp_zero, rsp_err);
        end
    endtask

    task automatic test_port0_add;
        int lat;
        logic ok;
        issue(0, 6'b000000, 32'd5, 32'd7, lat, ok);
        checks++;
        if (!ok || lat != 2) begin
            failures++;
            $display("FAIL add_latency got=%0d ok=%b exp=2", lat, ok);
        end
        checks++;
        if ({rsp_valid, rsp_data, rsp_zero, rsp_err} !== {2'b01, 32'd12, 2'b00}) begin
            failures++;
            $display("FAIL add_result got=%b/%0d/%b/%b exp=01/12/0/0",
                     rsp_valid, rsp_data, rsp_zero, rsp_err);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic ok;
        rsp_ready = 2'b01;
        issue(1, 6'b110000, 32'd9, 32'd9, lat, ok);
        checks++;
        if (!ok || lat != 2) begin
            failures++;
            $display("FAIL bp_latency got=%0d ok=%b exp=2", lat, ok);
        end
        set_port(0, 6'b000000, 32'd1, 32'd1);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_zero, rsp_err, req_ready} !==
                {2'b10, 32'd0, 2'b10, 2'b00}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%b/%b rr=%b exp=10/0/1/0 rr=00",
                         i, rsp_valid, rsp_data, rsp_zero, rsp_err, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin
            failures++;
            $display("FAIL bp_release got=%b rr=%b exp=00 rr=01", rsp_valid, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_arbitration;
        int ngrant = 0;
        int nrsp = 0;
        logic pend [$];
        logic g, exp_g, po;
        @(negedge clk);
        set_port(0, 6'b000000, 32'd1, 32'd1);
        set_port(1, 6'b000000, 32'd2, 32'd2);
        req_valid = 2'b11;
        for (int c = 0; c < 60 && nrsp < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (ngrant == 4) req_valid = 2'b00;
            if (rsp_valid != 2'b00 && pend.size() > 0) begin
                po = pend.pop_front();
                nrsp++;
                checks++;
                if (rsp_valid !== (po ? 2'b10 : 2'b01) ||
                    rsp_data !== (po ? 32'd4 : 32'd2)) begin
                    failures++;
                    $display("FAIL arb_rsp n=%0d got=%b/%0d exp_port=%0d",
                             nrsp, rsp_valid, rsp_data, po);
                end
            end
            #1;
            if (ngrant < 4 && (req_ready & req_valid) != 2'b00) begin
                g = req_ready[1];
                exp_g = tie_winner(model_lg);
                checks++;
                if (g !== exp_g) begin
                    failures++;
                    $display("FAIL arb_grant n=%0d got=%0d exp=%0d", ngrant, g, exp_g);
                end
                model_lg = g;
                pend.push_back(g);
                ngrant++;
            end
        end
        req_valid = 2'b00;
        checks++;
        if (nrsp != 4) begin
            failures++;
            $display("FAIL arb_timeout got=%0d exp=4", nrsp);
        end
    endtask

    task automatic test_special_ops;
        logic [5:0]  ops [3] = '{6'b110101, 6'b000011, 6'b000010};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'd1, 32'd1};
        logic [31:0] bs  [3] = '{32'h0000_0024, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [3] = '{32'hF800_0000, 32'd1, 32'd0};
        int lat;
        logic ok;
        for (int i = 0; i < 3; i++) begin
            issue(i % 2, ops[i], as[i], bs[i], lat, ok);
            checks++;
            if (!ok || rsp_data !== ex[i] || rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL special_op%0d got=%h err=%b ok=%b exp=%h",
                         i, rsp_data, rsp_err, ok, ex[i]);
            end
        end
    endtask

    task automatic test_illegal;
        int lat;
        logic ok;
        issue(0, 6'b111111, 32'd0, 32'd0, lat, ok);
        checks++;
        if (!ok || {rsp_err, rsp_data, rsp_zero} !== {1'b1, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL illegal got=%b/%h/%b exp=1/0/0", rsp_err, rsp_data, rsp_zero);
        end
        issue(1, 6'b000000, 32'd3, 32'd4, lat, ok);
        checks++;
        if (!ok || {rsp_err, rsp_data} !== {1'b0, 32'd7}) begin
            failures++;
            $display("FAIL after_illegal got=%b/%0d exp=0/7", rsp_err, rsp_data);
        end
    endtask

    task automatic test_random;
        logic [5:0] op_tab [11] = '{6'b000000, 6'b110000, 6'b000010, 6'b000011,
                                    6'b000100, 6'b000110, 6'b000111, 6'b100000,
                                    6'b100101, 6'b110101, 6'b000000};
        logic [5:0]  op;
        logic [31:0] a, b;
        logic [33:0] e;
        int p, lat;
        logic ok;
        for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(0, 1));
            op = op_tab[$urandom_range(0, 10)];
            if (i % 8 == 7) op = 6'($urandom);
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            e = ref_op(op, a, b);
            issue(p, op, a, b, lat, ok);
            checks++;
            if (!ok || lat != 2 || {rsp_err, rsp_zero, rsp_data} !== e) begin
                failures++;
                $display("FAIL rand%0d op=%b got=%b/%b/%h lat=%0d exp=%b/%b/%h",
                         i, op, rsp_err, rsp_zero, rsp_data, lat, e[33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic ok = 1'b0;
        @(negedge clk);
        set_port(1, 6'b000000, 32'd5, 32'd6);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid_accept got=%b exp=10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_lg = 1'b1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_idle got=%b/%h exp=00/0", rsp_valid, rsp_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00) begin
                failures++;
                $display("FAIL rst_mid_noresp cyc=%0d got=%b exp=00", i, rsp_valid);
            end
        end
        set_port(0, 6'b000100, 32'hF0, 32'h0F);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rst_mid_tie got=%b exp=01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid == 2'b01) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || rsp_data !== 32'hFF) begin
            failures++;
            $display("FAIL rst_mid_next ok=%b got=%h exp=ff", ok, rsp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_a1 = '0;
        req_b0 = '0; req_b1 = '0;
        model_lg = 1'b1;
        test_reset();
        test_port0_add();
        test_backpressure();
        test_arbitration();
        test_special_ops();
        test_illegal();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
